// File: rtl/rom_program_loader.sv
// rom_program_loader: writer side of the Hack instruction ROM.
// Takes a big-endian byte stream (word count, then words) over a valid/ready
// handshake and writes the words to the instruction memory starting at
// address 0. The CPU is held in reset while a load is running.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN. When it is defined, two
// checksum bytes follow the image. The checksum is the 16-bit sum of the
// written words.
module rom_program_loader #(
   parameter int ADDR_WIDTH = 15,
   parameter int MAX_WORDS  = 32768
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [15:0]           wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_reset_hold
);

   typedef enum logic [3:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK_HI,
      CHK_LO,
`endif
      FINISH
   } state_t;

   state_t                state;
   state_t                next_state;

   logic [ADDR_WIDTH-1:0] addr;       // address of the next word to write
   logic [15:0]           remaining;  // words still to be written
   logic [7:0]            len_hi;
   logic [7:0]            hi_byte;
   logic [15:0]           len_word;
   logic                  len_too_big;
   logic                  accept;
   logic                  set_done;
   logic                  set_error;
   logic                  last_word;

`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]            chk_hi;
   logic [15:0]           sum;
`endif

   assign len_word       = {len_hi, in_data};
   assign len_too_big    = {16'd0, len_word} > 32'(MAX_WORDS);
   assign accept         = in_ready && in_valid;
   assign last_word      = (remaining == 16'd1);
   assign cpu_reset_hold = busy;

   // State register; reset returns to IDLE from any point in a load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples the values from before the clock edge.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state decode and the per-state handshake and strobe outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path can leave one
      // unassigned and infer a latch.
      next_state = state;
      in_ready   = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b1;
      set_done   = 1'b0;
      set_error  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = LEN_HI;
         end
         LEN_HI: begin
            in_ready = 1'b1;
            if (in_valid) next_state = LEN_LO;
         end
         LEN_LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (len_word == 16'd0) begin
                  next_state = FINISH;
               end else if (len_too_big) begin
                  set_error  = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = DAT_HI;
               end
            end
         end
         DAT_HI: begin
            in_ready = 1'b1;
            if (in_valid) next_state = DAT_LO;
         end
         DAT_LO: begin
            in_ready = 1'b1;
            if (in_valid) next_state = WRITE;
         end
         WRITE: begin
            wr_en = 1'b1;
            if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
               next_state = CHK_HI;
`else
               next_state = FINISH;
`endif
            end else begin
               next_state = DAT_HI;
            end
         end
`ifdef ROM_LOADER_CHECKSUM_EN
         CHK_HI: begin
            in_ready = 1'b1;
            if (in_valid) next_state = CHK_LO;
         end
         CHK_LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if ({chk_hi, in_data} == sum) begin
                  next_state = FINISH;
               end else begin
                  set_error  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
`endif
         FINISH: begin
            set_done   = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: byte capture, word assembly, address/count tracking, and the
   // sticky status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr      <= '0;
         remaining <= '0;
         len_hi    <= '0;
         hi_byte   <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         chk_hi    <= '0;
         sum       <= '0;
`endif
      end else begin
         if (state == IDLE && start) begin
            addr    <= '0;
            wr_addr <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
         end
         if (state == LEN_HI && accept) len_hi    <= in_data;
         if (state == LEN_LO && accept) remaining <= len_word;
         if (state == DAT_HI && accept) hi_byte   <= in_data;
         // wr_addr/wr_data only move when a new word is ready; otherwise
         // they keep showing the last word written.
         if (state == DAT_LO && accept) begin
            wr_data <= {hi_byte, in_data};
            wr_addr <= addr;
         end
         if (state == WRITE) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum       <= sum + wr_data;
`endif
         end
`ifdef ROM_LOADER_CHECKSUM_EN
         if (state == CHK_HI && accept) chk_hi <= in_data;
`endif
         if (set_done)  done  <= 1'b1;
         if (set_error) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rom_program_loader.sv
// Directed testbench for rom_program_loader. Expected values are
// hand-computed constants. A small memory captures every wr_en pulse.
module tb_rom_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_reset_hold;

   int checks = 0;
   int errors = 0;

   int          wr_count = 0;
   logic [14:0] log_addr [16];
   logic [15:0] log_data [16];
   logic [15:0] mem [32];
   int          wr_ready_bad  = 0;
   int          hold_mismatch = 0;
   int          hold_drop     = 0;
   bit          loading       = 1'b0;

   rom_program_loader #(.ADDR_WIDTH(15), .MAX_WORDS(32768)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .cpu_reset_hold (cpu_reset_hold)
   );

   always #5 clk = ~clk;

   // Capture writes into the ROM model and watch handshake invariants.
   always @(posedge clk) begin
      if (wr_en) begin
         if (wr_count < 16) begin
            log_addr[wr_count] = wr_addr;
            log_data[wr_count] = wr_data;
         end
         mem[wr_addr[4:0]] = wr_data;
         wr_count++;
         if (in_ready) wr_ready_bad++;
      end
      if (cpu_reset_hold !== busy) hold_mismatch++;
      if (loading && !cpu_reset_hold) hold_drop++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      check("byte_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
   endtask

   // Checksum bytes exist only in the checksum build.
   task automatic send_chk(input logic [15:0] c, input int gap);
`ifdef ROM_LOADER_CHECKSUM_EN
      send_word(c, gap);
`else
      if (gap < 0) in_data = c[7:0];
`endif
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 40) begin
         tick();
         t++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Image: EC10, 0005, E308; checksum EC10+0005+E308 = 0xCF1D mod 2^16.
   task automatic load_basic(input int gap);
      wr_count = 0;
      start_load();
      loading = 1'b1;
      send_word(16'h0003, gap);
      send_word(16'hEC10, gap);
      send_word(16'h0005, gap);
      send_word(16'hE308, gap);
      send_chk(16'hCF1D, gap);
      loading = 1'b0;
      wait_idle();
   endtask

   task automatic check_basic(input string tag);
      check({tag, "_count"}, wr_count, 32'd3);
      check({tag, "_a0"}, {17'd0, log_addr[0]}, 32'd0);
      check({tag, "_d0"}, {16'd0, log_data[0]}, 32'hEC10);
      check({tag, "_a1"}, {17'd0, log_addr[1]}, 32'd1);
      check({tag, "_d1"}, {16'd0, log_data[1]}, 32'h0005);
      check({tag, "_a2"}, {17'd0, log_addr[2]}, 32'd2);
      check({tag, "_d2"}, {16'd0, log_data[2]}, 32'hE308);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_rom0"}, {16'd0, mem[0]}, 32'hEC10);
      check({tag, "_rom1"}, {16'd0, mem[1]}, 32'h0005);
      check({tag, "_rom2"}, {16'd0, mem[2]}, 32'hE308);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state: all outputs zero.
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_wr_addr", {17'd0, wr_addr}, 32'd0);
      check("rst_wr_data", {16'd0, wr_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_hold", {31'd0, cpu_reset_hold}, 32'd0);

      // Valid data without start is never accepted.
      in_data  = 8'hAA;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_no_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      check("idle_no_writes", wr_count, 32'd0);

      // Back-to-back three-word image.
      load_basic(0);
      check_basic("fast");

      // Same image with 7 idle cycles before every byte.
      load_basic(7);
      check_basic("slow");
      check("slow_hold_drop", hold_drop, 32'd0);
      check("write_ready_low", wr_ready_bad, 32'd0);

      // Zero-length image completes with no writes.
      wr_count = 0;
      start_load();
      send_word(16'h0000, 0);
      wait_idle();
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_error", {31'd0, error}, 32'd0);
      check("len0_writes", wr_count, 32'd0);

      // Oversized length (32769) is rejected.
      wr_count = 0;
      start_load();
      send_word(16'h8001, 0);
      tick();
      check("big_error", {31'd0, error}, 32'd1);
      check("big_done", {31'd0, done}, 32'd0);
      check("big_busy", {31'd0, busy}, 32'd0);
      check("big_writes", wr_count, 32'd0);

      // Reset after the second word of a four-word load.
      wr_count = 0;
      start_load();
      send_word(16'h0004, 0);
      send_word(16'h1111, 0);
      send_word(16'h2222, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("mid_writes", wr_count, 32'd2);
      check("mid_d1", {16'd0, log_data[1]}, 32'h2222);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_hold", {31'd0, cpu_reset_hold}, 32'd0);
      check("mid_done", {31'd0, done}, 32'd0);
      check("mid_error", {31'd0, error}, 32'd0);

      // A fresh load after the abort behaves normally.
      load_basic(0);
      check_basic("reload");

`ifdef ROM_LOADER_CHECKSUM_EN
      // Words 0001 + FFFF sum to 0000 modulo 2^16.
      wr_count = 0;
      start_load();
      send_word(16'h0002, 0);
      send_word(16'h0001, 0);
      send_word(16'hFFFF, 0);
      send_word(16'h0000, 0);
      wait_idle();
      check("chk_ok_done", {31'd0, done}, 32'd1);
      check("chk_ok_error", {31'd0, error}, 32'd0);
      check("chk_ok_writes", wr_count, 32'd2);

      wr_count = 0;
      start_load();
      send_word(16'h0002, 0);
      send_word(16'h0001, 0);
      send_word(16'hFFFF, 0);
      send_word(16'h0001, 0);
      wait_idle();
      check("chk_bad_done", {31'd0, done}, 32'd0);
      check("chk_bad_error", {31'd0, error}, 32'd1);
      check("chk_bad_writes", wr_count, 32'd2);
`endif

      check("hold_equals_busy", hold_mismatch, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
